// File: rtl/line_fill_buffer_if.sv
// Bus bundle between the line fill buffer, the pipeline / read sequencer
// side that drives it, and the cache data array that consumes the line.
// Handshake: a line is offered while line_valid=1 and is taken on the first
// rising edge with line_valid=1 and line_ack=1; line_valid, line_addr and
// line_data stay stable from assertion until that edge.
interface line_fill_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fill_start;
  logic [ADDR_W-1:0] fill_addr;
  logic              rd_valid;
  logic [1:0]        rd_index;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  logic              busy;
  logic              crit_valid;
  logic [DATA_W-1:0] crit_data;
  logic              line_valid;
  logic [ADDR_W-1:0] line_addr;
  logic [4*DATA_W-1:0] line_data;
  logic              line_ack;
  logic              err;
  logic [1:0]        fsm_state;   // debug view of the buffer FSM

  // Environment side: issues misses, supplies memory words, acks lines.
  modport master (
    output fill_start, fill_addr, rd_valid, rd_index, rd_data, rd_done, line_ack,
    input  busy, crit_valid, crit_data, line_valid, line_addr, line_data, err, fsm_state
  );

  // Buffer side.
  modport slave (
    input  fill_start, fill_addr, rd_valid, rd_index, rd_data, rd_done, line_ack,
    output busy, crit_valid, crit_data, line_valid, line_addr, line_data, err, fsm_state
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Line fill buffer: collects the four words of a missed line from the read
// sequencer in any order, forwards the requested word as soon as it lands,
// then offers the whole line to the cache data array until acknowledged.
module line_fill_buffer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  line_fill_buffer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          mask;
  logic [1:0]          crit_idx;
  logic [DATA_W-1:0]   words [4];
  logic                busy_r;
  logic                crit_valid_r;
  logic [DATA_W-1:0]   crit_data_r;
  logic                line_valid_r;
  logic [ADDR_W-1:0]   line_addr_r;
  logic                err_r;

  // Mask as it will look after this cycle's capture; decides completion
  // versus early-done in the same cycle the last word arrives.
  logic [3:0]          idx_bit;
  logic [3:0]          mask_next;

  // Capture bookkeeping for the current sequencer word.
  always_comb begin
    idx_bit   = 4'b0001 << bus.rd_index;
    mask_next = mask;
    if (bus.rd_valid) begin
      mask_next = mask | idx_bit;
    end
  end

  // Fill FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mask         <= 4'b0000;
      crit_idx     <= 2'd0;
      busy_r       <= 1'b0;
      crit_valid_r <= 1'b0;
      crit_data_r  <= '0;
      line_valid_r <= 1'b0;
      line_addr_r  <= '0;
      err_r        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        words[i] <= '0;
      end
    end else begin
      crit_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fill_start) begin
            state       <= FILL;
            busy_r      <= 1'b1;
            line_addr_r <= {bus.fill_addr[ADDR_W-1:3], 3'b000};
            crit_idx    <= bus.fill_addr[2:1];
            mask        <= 4'b0000;
            err_r       <= 1'b0;
          end
        end
        FILL: begin
          if (bus.rd_valid) begin
            words[bus.rd_index] <= bus.rd_data;
            mask                <= mask_next;
            // Forward only the first arrival of the requested word.
            if ((bus.rd_index == crit_idx) && !mask[bus.rd_index]) begin
              crit_valid_r <= 1'b1;
              crit_data_r  <= bus.rd_data;
            end
          end
          if (mask_next == 4'b1111) begin
            state        <= PRESENT;
            line_valid_r <= 1'b1;
          end else if (bus.rd_done) begin
            // Sequencer finished with holes in the line: abandon it.
            state  <= IDLE;
            busy_r <= 1'b0;
            err_r  <= 1'b1;
          end
        end
        PRESENT: begin
          if (bus.line_ack) begin
            state        <= IDLE;
            line_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy_r       <= 1'b0;
          line_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.crit_valid = crit_valid_r;
  assign bus.crit_data  = crit_data_r;
  assign bus.line_valid = line_valid_r;
  assign bus.line_addr  = line_addr_r;
  assign bus.line_data  = {words[3], words[2], words[1], words[0]};
  assign bus.err        = err_r;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: directed fills with a scoreboard of expected
// critical words and assembled lines.
module tb_line_fill_buffer;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;

  logic clk;
  logic rst;

  line_fill_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  line_fill_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int crit_pulses = 0;

  logic [DATA_W-1:0]   crit_q [$];
  logic [4*DATA_W-1:0] line_q [$];

  // Bench model of the fill in progress.
  logic [1:0]        m_crit;
  logic [3:0]        m_seen;
  logic [DATA_W-1:0] m_words [4];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Critical-word monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (rst && bus.crit_valid === 1'b1) begin
      crit_pulses++;
      if (crit_q.size() == 0) begin
        check("crit_unexpected", 64'd1, 64'd0);
      end else begin
        check("crit_data", {48'd0, bus.crit_data}, {48'd0, crit_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fill_start = 1'b0;
    bus.fill_addr  = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_index   = 2'd0;
    bus.rd_data    = '0;
    bus.rd_done    = 1'b0;
    bus.line_ack   = 1'b0;
  endtask

  task automatic start_fill(input logic [ADDR_W-1:0] addr);
    bus.fill_start = 1'b1;
    bus.fill_addr  = addr;
    m_crit = addr[2:1];
    m_seen = 4'b0000;
    tick();
    bus.fill_start = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] idx, input logic [DATA_W-1:0] data,
                           input logic done);
    bus.rd_valid = 1'b1;
    bus.rd_index = idx;
    bus.rd_data  = data;
    bus.rd_done  = done;
    if (idx == m_crit && !m_seen[idx]) crit_q.push_back(data);
    m_seen[idx]  = 1'b1;
    m_words[idx] = data;
    if (m_seen == 4'b1111) line_q.push_back({m_words[3], m_words[2], m_words[1], m_words[0]});
    tick();
    bus.rd_valid = 1'b0;
    bus.rd_done  = 1'b0;
  endtask

  task automatic expect_line(input string tag, input logic [ADDR_W-1:0] addr);
    check({tag, "_valid"}, {63'd0, bus.line_valid}, 64'd1);
    check({tag, "_addr"}, {48'd0, bus.line_addr}, {48'd0, addr});
    if (line_q.size() == 0) check({tag, "_q_empty"}, 64'd1, 64'd0);
    else check({tag, "_data"}, bus.line_data, line_q.pop_front());
  endtask

  task automatic ack_line();
    bus.line_ack = 1'b1;
    tick();
    bus.line_ack = 1'b0;
    check("ack_idle_state", {62'd0, bus.fsm_state}, {62'd0, S_IDLE});
    check("ack_line_valid", {63'd0, bus.line_valid}, 64'd0);
    check("ack_busy", {63'd0, bus.busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses_before;
    logic [63:0] held;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_line_valid", {63'd0, bus.line_valid}, 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
    check("rst_line_data", bus.line_data, 64'd0);
    check("rst_state", {62'd0, bus.fsm_state}, {62'd0, S_IDLE});

    // Ordered fill, critical index 2.
    start_fill(16'h1234);
    check("of_busy", {63'd0, bus.busy}, 64'd1);
    check("of_state", {62'd0, bus.fsm_state}, {62'd0, S_FILL});
    send_word(2'd0, 16'hA000, 1'b0);
    send_word(2'd1, 16'hA001, 1'b0);
    send_word(2'd2, 16'hA002, 1'b0);
    check("of_crit_pulse", {63'd0, bus.crit_valid}, 64'd1);
    check("of_crit_word", {48'd0, bus.crit_data}, 64'h0000_0000_0000_A002);
    check("of_lv_early", {63'd0, bus.line_valid}, 64'd0);
    send_word(2'd3, 16'hA003, 1'b1);
    check("of_crit_one_cycle", {63'd0, bus.crit_valid}, 64'd0);
    check("of_line_abs", bus.line_data, 64'hA003_A002_A001_A000);
    expect_line("of_line", 16'h1230);
    held = bus.line_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("of_hold_valid", {63'd0, bus.line_valid}, 64'd1);
      check("of_hold_data", bus.line_data, held);
      check("of_hold_addr", {48'd0, bus.line_addr}, 64'h1230);
    end
    ack_line();
    check("of_retain_data", bus.line_data, 64'hA003_A002_A001_A000);

    // Out-of-order with duplicate, critical index 1.
    pulses_before = crit_pulses;
    start_fill(16'h4562);
    send_word(2'd3, 16'hC003, 1'b0);
    send_word(2'd1, 16'hC001, 1'b0);
    send_word(2'd1, 16'hBBBB, 1'b0);
    send_word(2'd0, 16'hC000, 1'b0);
    check("oo_lv_early", {63'd0, bus.line_valid}, 64'd0);
    send_word(2'd2, 16'hC002, 1'b1);
    check("oo_line_abs", bus.line_data, 64'hC003_C002_BBBB_C000);
    expect_line("oo_line", 16'h4560);
    tick();
    check("oo_crit_count", 64'(crit_pulses - pulses_before), 64'd1);
    ack_line();

    // Early done.
    start_fill(16'h0000);
    send_word(2'd0, 16'hE000, 1'b0);
    send_word(2'd1, 16'hE001, 1'b0);
    send_word(2'd2, 16'hE002, 1'b1);
    check("ed_err", {63'd0, bus.err}, 64'd1);
    check("ed_state", {62'd0, bus.fsm_state}, {62'd0, S_IDLE});
    check("ed_busy", {63'd0, bus.busy}, 64'd0);
    check("ed_lv", {63'd0, bus.line_valid}, 64'd0);
    tick();
    tick();
    check("ed_err_sticky", {63'd0, bus.err}, 64'd1);
    check("ed_lv_late", {63'd0, bus.line_valid}, 64'd0);

    // Ignored requests during FILL and PRESENT.
    start_fill(16'h2228);
    check("ig_err_clear", {63'd0, bus.err}, 64'd0);
    bus.fill_start = 1'b1;
    bus.fill_addr  = 16'hFFFF;
    send_word(2'd0, 16'hF000, 1'b0);
    send_word(2'd1, 16'hF001, 1'b0);
    check("ig_fill_state", {62'd0, bus.fsm_state}, {62'd0, S_FILL});
    send_word(2'd2, 16'hF002, 1'b0);
    send_word(2'd3, 16'hF003, 1'b0);
    expect_line("ig_line", 16'h2228);
    tick();
    check("ig_present_state", {62'd0, bus.fsm_state}, {62'd0, S_PRESENT});
    check("ig_present_addr", {48'd0, bus.line_addr}, 64'h2228);
    ack_line();
    bus.fill_start = 1'b0;
    check("ig_after_ack_addr", {48'd0, bus.line_addr}, 64'h2228);
    tick();
    check("ig_no_restart", {62'd0, bus.fsm_state}, {62'd0, S_IDLE});

    // Mid-fill reset, then a fresh fill.
    start_fill(16'h3336);
    send_word(2'd0, 16'hD100, 1'b0);
    send_word(2'd1, 16'hD101, 1'b0);
    rst = 1'b0;
    #1;
    check("mr_busy", {63'd0, bus.busy}, 64'd0);
    check("mr_state", {62'd0, bus.fsm_state}, {62'd0, S_IDLE});
    check("mr_line_data", bus.line_data, 64'd0);
    check("mr_line_addr", {48'd0, bus.line_addr}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    start_fill(16'h3336);
    send_word(2'd2, 16'hD002, 1'b0);
    send_word(2'd0, 16'hD000, 1'b0);
    send_word(2'd3, 16'hD003, 1'b0);
    check("mr_crit_pulse", {63'd0, bus.crit_valid}, 64'd1);
    send_word(2'd1, 16'hD001, 1'b1);
    check("mr_line_abs", bus.line_data, 64'hD003_D002_D001_D000);
    expect_line("mr_line", 16'h3330);
    ack_line();
    tick();

    check("crit_q_drained", 64'(crit_q.size()), 64'd0);
    check("line_q_drained", 64'(line_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Sits directly downstream of the four-word memory read sequencer.
- On a cache miss it captures the four words the sequencer fetches, addressed by the sequencer's 2-bit word index.
- Forwards the critical (requested) word early to the pipeline.
- Presents the assembled line to the cache data array with a valid/ack handshake.

Parameters:
- ADDR_W, 16, byte-address width of fill_addr and line_addr.
- DATA_W, 16, word width; one line is 4 words.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- fill_start  in  1  miss request; accepted only in IDLE
- fill_addr  in  ADDR_W  byte address of missing access; [2:1] = critical word index
- rd_valid  in  1  memory word valid this cycle
- rd_index  in  2  word index of rd_data (from read sequencer)
- rd_data  in  DATA_W  memory read data
- rd_done  in  1  sequencer final-word indication
- busy  out  1  high in FILL and PRESENT
- crit_valid  out  1  one-cycle pulse, critical word available
- crit_data  out  DATA_W  critical word; valid when crit_valid=1
- line_valid  out  1  assembled line offered to cache
- line_addr  out  ADDR_W  fill_addr with bits [2:0] forced to 0
- line_data  out  4*DATA_W  word 3 in [4*DATA_W-1:3*DATA_W] ... word 0 in [DATA_W-1:0]
- line_ack  in  1  cache accepted line
- err  out  1  sticky: rd_done arrived before all 4 words captured

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - busy, crit_valid, line_valid, err = 0.
  - line_addr, line_data, crit_data, word mask = 0.
- States IDLE, FILL, PRESENT; 2-bit encoded, registered.
- IDLE:
  - fill_start=1 -> FILL next cycle.
  - Latch line_addr and critical index = fill_addr[2:1].
  - Clear word mask and err.
  - busy=1 from the next cycle.
  - rd_valid, rd_done and line_ack are ignored.
- FILL, on rd_valid=1:
  - word[rd_index] <= rd_data and mask[rd_index] <= 1.
  - A repeated index overwrites the word; the mask bit is already set.
- Critical forward:
  - When the captured index equals the critical index and that mask bit was previously clear, crit_valid=1 and crit_data=rd_data the following cycle, for exactly one cycle.
  - A duplicate capture of the critical index does not re-pulse.
- Completion:
  - If the mask including the current write becomes 4'b1111 -> PRESENT next cycle; line_valid=1 that cycle.
  - This holds regardless of rd_done.
- Early done:
  - rd_done=1 with the mask including the current write != 4'b1111 -> IDLE next cycle and err=1.
  - line_valid never asserts for this fill.
  - err holds until the next accepted fill_start.
- fill_start in FILL or PRESENT is ignored; no queueing.
- PRESENT:
  - line_valid, line_addr and line_data are held stable until line_ack=1.
  - On the ack cycle -> IDLE next cycle; line_valid and busy drop to 0.
  - line_data and line_addr retain their last values.
  - rd_valid is ignored.
- line_ack outside PRESENT is ignored.
- line_ack and fill_start in the same PRESENT cycle: the ack is taken and fill_start is ignored. A new fill needs fill_start in IDLE.
- Latency:
  - fill_start to busy: 1 cycle.
  - 4th word capture to line_valid: 1 cycle.
  - Critical word capture to crit_valid: 1 cycle.
- Reset asserted mid-FILL or mid-PRESENT aborts immediately; all outputs return to reset values asynchronously.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> busy=0, line_valid=0, err=0, line_data=0.
- Ordered fill:
  - Stimulus: fill_start with fill_addr=16'h1234 (critical index 2); words 0..3 = 16'hA000..16'hA003 on consecutive cycles, with rd_done on word 3.
  - Required: crit_valid pulses one cycle after word 2 with crit_data=16'hA002.
  - Required: line_valid the cycle after word 3, line_addr=16'h1230, line_data=64'hA003_A002_A001_A000.
  - Required: line_ack held low 3 cycles keeps everything stable; ack -> IDLE next cycle.
- Out-of-order and duplicate:
  - Stimulus: indices 3, 1, 1 (second time 16'hBBBB), 0, 2; critical index 1.
  - Required: exactly one crit_valid, carrying the first index-1 word.
  - Required: final word1=16'hBBBB; line_valid only after index 2 arrives.
- Early done:
  - Stimulus: capture indices 0 and 1, then rd_done with index 2.
  - Required: err=1, state IDLE, line_valid stays 0.
  - Required: next fill_start clears err.
- Ignored requests: fill_start during FILL and during PRESENT (including the line_ack cycle) -> no restart, line_addr unchanged, IDLE after ack.
- Mid-fill reset: rst=0 after 2 captured words -> outputs cleared immediately; after release, a fresh full fill completes correctly.
